// File: rtl/fairy_decode_stage.sv
// fairy_decode_stage: MIPS-subset instruction decode with branch resolution, forwarding,
// hazard stall and the ID/EX pipeline register.
// Optional perf counters are enabled by defining FAIRY_DECODE_PERF_EN.
module fairy_decode_stage #(
   parameter logic [31:0] RESET_PC       = 32'h00000000,
   parameter int          NUM_HAZARD_SRC = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   input  logic        unaligned_addr_i,
   input  logic        exception_i,
   input  logic        eret_i,
   input  logic        stall_i,
   output logic [4:0]  rf_raddr1_o,
   output logic [4:0]  rf_raddr2_o,
   input  logic [31:0] rf_rdata1_i,
   input  logic [31:0] rf_rdata2_i,
   input  logic        ex_wen_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic        ex_is_load_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        mem_wen_i,
   input  logic [4:0]  mem_waddr_i,
   input  logic        mem_is_load_i,
   input  logic [31:0] mem_wdata_i,
   output logic        branch_valid_o,
   output logic [31:0] branch_target_o,
   output logic        stall_o,
   output logic [31:0] ex_inst_o,
   output logic [31:0] ex_pc_o,
   output logic [31:0] ex_op1_o,
   output logic [31:0] ex_op2_o,
   output logic [4:0]  ex_waddr_o,
   output logic [3:0]  ex_exc_o,
`ifdef FAIRY_DECODE_PERF_EN
   output logic        ex_eret_o,
   output logic [31:0] perf_stall_cnt_o,
   output logic [31:0] perf_branch_cnt_o
`else
   output logic        ex_eret_o
`endif
);
   // a fetch address error turns the slot into a bubble before decode
   logic [31:0] inst;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   assign inst = unaligned_addr_i ? 32'h0 : inst_i;
   assign op   = inst[31:26];
   assign fn   = inst[5:0];
   assign rs   = inst[25:21];
   assign rt   = inst[20:16];
   assign rd   = inst[15:11];
   assign imm  = inst[15:0];
   assign rf_raddr1_o = rs;
   assign rf_raddr2_o = rt;

   logic is_r, r_alu, is_jr, is_jalr, is_sys, is_brk, is_regimm, is_j, is_jal;
   logic is_beq, is_bne, is_blez, is_bgtz, i_alu, is_zext, is_lui, is_load, is_store;
   logic is_mfc0, is_mtc0, is_eret, valid, ri, use1, use2, is_bj, use_imm, link;
   assign is_r      = op == 6'h00;
   assign r_alu     = is_r & (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                         6'h26, 6'h27, 6'h2a, 6'h2b});
   assign is_jr     = is_r & fn == 6'h08;
   assign is_jalr   = is_r & fn == 6'h09;
   assign is_sys    = is_r & fn == 6'h0c;
   assign is_brk    = is_r & fn == 6'h0d;
   assign is_regimm = op == 6'h01 & rt[4:1] == 4'h0;
   assign is_j      = op == 6'h02;
   assign is_jal    = op == 6'h03;
   assign is_beq    = op == 6'h04;
   assign is_bne    = op == 6'h05;
   assign is_blez   = op == 6'h06;
   assign is_bgtz   = op == 6'h07;
   assign i_alu     = op[5:3] == 3'b001;
   assign is_zext   = op inside {6'h0c, 6'h0d, 6'h0e};
   assign is_lui    = op == 6'h0f;
   assign is_load   = op inside {6'h20, 6'h23, 6'h24};
   assign is_store  = op inside {6'h28, 6'h2b};
   assign is_mfc0   = op == 6'h10 & rs == 5'h00;
   assign is_mtc0   = op == 6'h10 & rs == 5'h04;
   assign is_eret   = inst == 32'h42000018;
   assign valid     = r_alu | is_jr | is_jalr | is_sys | is_brk | is_regimm | is_j | is_jal |
                      is_beq | is_bne | is_blez | is_bgtz | i_alu | is_load | is_store |
                      is_mfc0 | is_mtc0 | is_eret;
   assign ri        = !valid;
   assign use1      = r_alu | is_jr | is_jalr | is_regimm | is_beq | is_bne | is_blez |
                      is_bgtz | i_alu | is_load | is_store;
   assign use2      = r_alu | is_beq | is_bne | is_store | is_mtc0;
   assign is_bj     = is_regimm | is_beq | is_bne | is_blez | is_bgtz | is_jr | is_jalr;
   assign use_imm   = i_alu | is_load | is_store;
   assign link      = is_jal | is_jalr;

   logic [4:0] waddr;
   assign waddr = (r_alu | is_jalr) ? rd : (i_alu | is_load | is_mfc0) ? rt : is_jal ? 5'd31 : 5'd0;

   logic [31:0] imm_ext;
   assign imm_ext = is_zext ? {16'h0, imm} : is_lui ? {imm, 16'h0} : {{16{imm[15]}}, imm};

   // operand forwarding: EX non-load result first, then MEM, then the regfile
   logic [31:0] fwd1, fwd2;
   assign fwd1 = rs == 5'd0 ? 32'h0 :
                 (ex_wen_i & !ex_is_load_i & ex_waddr_i == rs) ? ex_wdata_i :
                 (mem_wen_i & mem_waddr_i == rs) ? mem_wdata_i : rf_rdata1_i;
   assign fwd2 = rt == 5'd0 ? 32'h0 :
                 (ex_wen_i & !ex_is_load_i & ex_waddr_i == rt) ? ex_wdata_i :
                 (mem_wen_i & mem_waddr_i == rt) ? mem_wdata_i : rf_rdata2_i;

   logic ex_m, mem_m, haz;
   assign ex_m  = (use1 & rs != 5'd0 & ex_waddr_i == rs) | (use2 & rt != 5'd0 & ex_waddr_i == rt);
   assign mem_m = (use1 & rs != 5'd0 & mem_waddr_i == rs) | (use2 & rt != 5'd0 & mem_waddr_i == rt);
   assign haz   = (ex_is_load_i & ex_m) | (mem_is_load_i & mem_m) | (is_bj & ex_wen_i & ex_m);
   assign stall_o = haz | stall_i;

   logic [31:0] pc4, pc8;
   logic        taken;
   assign pc4   = pc_i + 32'd4;
   assign pc8   = pc_i + 32'd8;
   assign taken = (is_beq & fwd1 == fwd2) | (is_bne & fwd1 != fwd2) |
                  (is_blez & (fwd1[31] | fwd1 == 32'h0)) | (is_bgtz & !fwd1[31] & fwd1 != 32'h0) |
                  (is_regimm & (fwd1[31] ^ rt[0])) | is_j | is_jal | is_jr | is_jalr;
   assign branch_valid_o  = taken & !stall_o;
   assign branch_target_o = (is_j | is_jal) ? {pc4[31:28], inst[25:0], 2'b00} :
                            (is_jr | is_jalr) ? fwd1 : pc4 + {{14{imm[15]}}, imm, 2'b00};

   // ID/EX register: flush > downstream stall hold > hazard bubble > capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || exception_i || eret_i || (haz && !stall_i)) begin
         ex_inst_o  <= 32'h0;
         ex_pc_o    <= RESET_PC;
         ex_op1_o   <= 32'h0;
         ex_op2_o   <= 32'h0;
         ex_waddr_o <= 5'd0;
         ex_exc_o   <= 4'h0;
         ex_eret_o  <= 1'b0;
      end else if (!stall_i) begin
         ex_inst_o  <= inst;
         ex_pc_o    <= pc_i;
         ex_op1_o   <= link ? pc8 : fwd1;
         ex_op2_o   <= link ? 32'h0 : use_imm ? imm_ext : fwd2;
         ex_waddr_o <= waddr;
         ex_exc_o   <= {unaligned_addr_i, ri, is_sys, is_brk};
         ex_eret_o  <= is_eret;
      end
   end

`ifdef FAIRY_DECODE_PERF_EN
   // hazard-stall and redirect counters, untouched by pipeline flushes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cnt_o  <= 32'h0;
         perf_branch_cnt_o <= 32'h0;
      end else begin
         perf_stall_cnt_o  <= perf_stall_cnt_o + {31'h0, haz};
         perf_branch_cnt_o <= perf_branch_cnt_o + {31'h0, branch_valid_o};
      end
   end
`endif
endmodule

// File: tb/tb_fairy_decode_stage.sv
// tb_fairy_decode_stage: directed vectors for the decode stage.
module tb_fairy_decode_stage;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] inst_i, pc_i;
   logic        unaligned_addr_i, exception_i, eret_i, stall_i;
   logic [4:0]  rf_raddr1_o, rf_raddr2_o;
   logic [31:0] rf_rdata1_i, rf_rdata2_i;
   logic        ex_wen_i, ex_is_load_i, mem_wen_i, mem_is_load_i;
   logic [4:0]  ex_waddr_i, mem_waddr_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic        branch_valid_o, stall_o, ex_eret_o;
   logic [31:0] branch_target_o, ex_inst_o, ex_pc_o, ex_op1_o, ex_op2_o;
   logic [4:0]  ex_waddr_o;
   logic [3:0]  ex_exc_o;
   int checks = 0;
   int failures = 0;

   localparam logic [31:0] ADDU  = 32'h010a4821;
   localparam logic [31:0] BEQ   = 32'h10220004;
   localparam logic [31:0] JAL   = 32'h0ff00040;
   localparam logic [31:0] ADDIU = 32'h2405ffff;

   fairy_decode_stage dut (
      .clk(clk), .reset_n(reset_n), .inst_i(inst_i), .pc_i(pc_i),
      .unaligned_addr_i(unaligned_addr_i), .exception_i(exception_i), .eret_i(eret_i),
      .stall_i(stall_i), .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
      .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i), .ex_wen_i(ex_wen_i),
      .ex_waddr_i(ex_waddr_i), .ex_is_load_i(ex_is_load_i), .ex_wdata_i(ex_wdata_i),
      .mem_wen_i(mem_wen_i), .mem_waddr_i(mem_waddr_i), .mem_is_load_i(mem_is_load_i),
      .mem_wdata_i(mem_wdata_i), .branch_valid_o(branch_valid_o),
      .branch_target_o(branch_target_o), .stall_o(stall_o), .ex_inst_o(ex_inst_o),
      .ex_pc_o(ex_pc_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_waddr_o(ex_waddr_o),
      .ex_exc_o(ex_exc_o), .ex_eret_o(ex_eret_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      inst_i = 0; pc_i = 0; unaligned_addr_i = 0; exception_i = 0; eret_i = 0; stall_i = 0;
      rf_rdata1_i = 0; rf_rdata2_i = 0; ex_wen_i = 0; ex_waddr_i = 0; ex_is_load_i = 0;
      ex_wdata_i = 0; mem_wen_i = 0; mem_waddr_i = 0; mem_is_load_i = 0; mem_wdata_i = 0;
   endtask

   initial begin
      quiet();
      reset_n = 1'b0;
      step(); step();
      check("rst_pc", ex_pc_o, 32'h0);
      check("rst_inst", ex_inst_o, 32'h0);
      check("rst_exc", {28'h0, ex_exc_o}, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'h0);
      check("rst_bv", {31'h0, branch_valid_o}, 32'h0);
      reset_n = 1'b1;
      inst_i = ADDU; pc_i = 32'h100; rf_rdata1_i = 5; rf_rdata2_i = 7;
      #1;
      check("addu_raddr1", {27'h0, rf_raddr1_o}, 8);
      check("addu_raddr2", {27'h0, rf_raddr2_o}, 10);
      check("addu_stall", {31'h0, stall_o}, 0);
      step();
      check("addu_inst", ex_inst_o, ADDU);
      check("addu_op1", ex_op1_o, 5);
      check("addu_op2", ex_op2_o, 7);
      check("addu_waddr", {27'h0, ex_waddr_o}, 9);
      check("addu_pc", ex_pc_o, 32'h100);
      #2 reset_n = 1'b0;
      #1;
      check("async_inst", ex_inst_o, 0);
      check("async_waddr", {27'h0, ex_waddr_o}, 0);
      reset_n = 1'b1;
      step();
      // load-use: LW to $8 sitting in EX
      ex_is_load_i = 1; ex_wen_i = 1; ex_waddr_i = 8;
      #1 check("lu_stall", {31'h0, stall_o}, 1);
      step();
      check("lu_bubble", ex_inst_o, 0);
      check("lu_bubble_wa", {27'h0, ex_waddr_o}, 0);
      ex_is_load_i = 0; ex_wen_i = 0; mem_wen_i = 1; mem_waddr_i = 8; mem_wdata_i = 32'hdeadbeef;
      #1 check("lu_release", {31'h0, stall_o}, 0);
      step();
      check("mem_fwd_op1", ex_op1_o, 32'hdeadbeef);
      check("mem_fwd_op2", ex_op2_o, 7);
      ex_wen_i = 1; ex_waddr_i = 10; ex_wdata_i = 32'h1234;
      step();
      check("ex_fwd_op2", ex_op2_o, 32'h1234);
      quiet();
      // BEQ $1,$2,+4
      inst_i = BEQ; pc_i = 32'hbfc00010; rf_rdata1_i = 32'h55; rf_rdata2_i = 32'h55;
      #1;
      check("beq_taken", {31'h0, branch_valid_o}, 1);
      check("beq_target", branch_target_o, 32'hbfc00024);
      rf_rdata2_i = 32'h56;
      #1 check("beq_nt", {31'h0, branch_valid_o}, 0);
      rf_rdata2_i = 32'h55; ex_wen_i = 1; ex_waddr_i = 2; ex_wdata_i = 32'h55;
      #1;
      check("beq_haz_stall", {31'h0, stall_o}, 1);
      check("beq_haz_bv", {31'h0, branch_valid_o}, 0);
      quiet();
      inst_i = JAL; pc_i = 32'hbfc00100;
      #1;
      check("jal_bv", {31'h0, branch_valid_o}, 1);
      check("jal_target", branch_target_o, 32'hbfc00100);
      step();
      check("jal_waddr", {27'h0, ex_waddr_o}, 31);
      check("jal_op1", ex_op1_o, 32'hbfc00108);
      check("jal_op2", ex_op2_o, 0);
      inst_i = 32'h34238000; rf_rdata1_i = 32'h99;
      step();
      check("ori_op2", ex_op2_o, 32'h00008000);
      check("ori_waddr", {27'h0, ex_waddr_o}, 3);
      inst_i = 32'h3c041234;
      step();
      check("lui_op2", ex_op2_o, 32'h12340000);
      inst_i = ADDIU;
      step();
      check("addiu_op2", ex_op2_o, 32'hffffffff);
      check("addiu_op1_r0", ex_op1_o, 0);
      // downstream stall holds, flush overrides it
      inst_i = ADDU; stall_i = 1;
      #1 check("stalli_stall", {31'h0, stall_o}, 1);
      step();
      check("stalli_hold", ex_inst_o, ADDIU);
      pc_i = 32'h40; exception_i = 1;
      step();
      check("flush_inst", ex_inst_o, 0);
      check("flush_pc", ex_pc_o, 32'h0);
      quiet();
      inst_i = JAL; pc_i = 32'h1234; unaligned_addr_i = 1;
      #1;
      check("adel_bv", {31'h0, branch_valid_o}, 0);
      check("adel_stall", {31'h0, stall_o}, 0);
      step();
      check("adel_exc", {28'h0, ex_exc_o}, 32'h8);
      check("adel_inst", ex_inst_o, 0);
      unaligned_addr_i = 0; inst_i = 32'hfc000000;
      step();
      check("ri_exc", {28'h0, ex_exc_o}, 32'h4);
      inst_i = 32'h0000000c;
      step();
      check("sys_exc", {28'h0, ex_exc_o}, 32'h2);
      inst_i = 32'h42000018;
      step();
      check("eret", {31'h0, ex_eret_o}, 1);
      check("eret_exc", {28'h0, ex_exc_o}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
